// File: rtl/protocore_pkg.sv
// Constants shared by the instruction decoder and the program loader.
// Holds the instruction layout, the HALT opcode and the loader state encoding.
package protocore_pkg;

  localparam int unsigned INSTR_W = 24;
  localparam int unsigned OPC_MSB = 23;
  localparam int unsigned OPC_LSB = 20;
  localparam logic [3:0]  OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_BYTE0 = 3'd1,
    LD_BYTE1 = 3'd2,
    LD_BYTE2 = 3'd3,
    LD_WRITE = 3'd4,
    LD_DONE  = 3'd5
  } loader_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Big-endian 3-byte shift register: the first byte pushed ends up in [23:16].
// Reports word_full once three bytes are held; clear restarts the count but keeps the word visible.
module loader_byte_packer
  import protocore_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               push,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_full
);

  logic [1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (push && (idx != 2'd3)) begin
      word <= {word[INSTR_W-9:0], byte_in};
      idx  <= idx + 2'd1;
    end
  end

  always_comb begin
    word_full = (idx == 2'd3);
  end

endmodule

// File: rtl/program_loader.sv
// Packs a byte stream into 24-bit instructions and writes them to sequential
// instruction memory addresses, holding the core in reset until a HALT word or a full memory.
module program_loader
  import protocore_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    word_count
);

  loader_state_e state, state_nxt;

  logic accept;
  logic start_ok;
  logic addr_last;
  logic word_halt;
  logic word_full;
  logic [INSTR_W-1:0] word;

  always_comb begin
    accept    = byte_valid && byte_ready;
    start_ok  = start && ((state == LD_IDLE) || (state == LD_DONE));
    addr_last = (imem_addr == '1);
    word_halt = is_halt(word);
  end

  loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok || (state == LD_WRITE)),
    .push      (accept),
    .byte_in   (byte_in),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LD_IDLE, LD_DONE: if (start) state_nxt = LD_BYTE0;
      LD_BYTE0:         if (accept) state_nxt = LD_BYTE1;
      LD_BYTE1:         if (accept) state_nxt = LD_BYTE2;
      LD_BYTE2:         if (accept) state_nxt = LD_WRITE;
      LD_WRITE:         state_nxt = (word_halt || addr_last) ? LD_DONE : LD_BYTE0;
      default:          state_nxt = LD_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state == LD_BYTE0) || (state == LD_BYTE1) || (state == LD_BYTE2);
    imem_we    = (state == LD_WRITE) && word_full;
    imem_wdata = word;
    cpu_hold   = (state != LD_DONE);
    done       = (state == LD_DONE);
  end

  // The address saturates at the last word so a full memory never wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_addr  <= '0;
      word_count <= '0;
      error      <= 1'b0;
    end else if (start_ok) begin
      imem_addr  <= '0;
      word_count <= '0;
      error      <= 1'b0;
    end else if (state == LD_WRITE) begin
      word_count <= word_count + 1'b1;
      if (!addr_last) begin
        imem_addr <= imem_addr + 1'b1;
      end
      if (!word_halt && addr_last) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the stimulus
// and matched by a monitor on every imem_we; end-of-load status is checked directly.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_valid, a_ready, a_we, a_hold, a_done, a_error;
  logic [7:0]  a_byte, a_addr;
  logic [23:0] a_wdata;
  logic [8:0]  a_count;

  logic        b_rst, b_start, b_valid, b_ready, b_we, b_hold, b_done, b_error;
  logic [7:0]  b_byte;
  logic [1:0]  b_addr;
  logic [23:0] b_wdata;
  logic [2:0]  b_count;

  program_loader #(.ADDR_W(8)) u_dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .byte_in(a_byte), .byte_valid(a_valid),
    .byte_ready(a_ready), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .cpu_hold(a_hold), .done(a_done), .error(a_error), .word_count(a_count)
  );

  program_loader #(.ADDR_W(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .byte_in(b_byte), .byte_valid(b_valid),
    .byte_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .cpu_hold(b_hold), .done(b_done), .error(b_error), .word_count(b_count)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (a_we) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_write actual=%0h:%0h required=none", a_addr, a_wdata);
      end else begin
        e = exp_a.pop_front();
        check("a_waddr", {24'd0, a_addr}, {24'd0, e[31:24]});
        check("a_wdata", {8'd0, a_wdata}, {8'd0, e[23:0]});
        check("a_ready_in_write", {31'd0, a_ready}, 32'd0);
      end
    end
    if (b_we) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_write actual=%0h:%0h required=none", b_addr, b_wdata);
      end else begin
        e = exp_b.pop_front();
        check("b_waddr", {30'd0, b_addr}, {24'd0, e[31:24]});
        check("b_wdata", {8'd0, b_wdata}, {8'd0, e[23:0]});
      end
    end
  end

  task automatic expect_write(input bit sel, input logic [7:0] addr, input logic [23:0] data);
    if (sel) exp_b.push_back({addr, data});
    else     exp_a.push_back({addr, data});
  endtask

  task automatic drive_byte(input bit sel, input logic [7:0] v, input int gap);
    int n;
    bit acc;
    repeat (gap) begin @(posedge clk); #1; end
    if (sel) begin b_byte = v; b_valid = 1'b1; end
    else     begin a_byte = v; a_valid = 1'b1; end
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      acc = sel ? b_ready : a_ready;
      @(posedge clk); #1;
      n++;
    end
    if (sel) b_valid = 1'b0; else a_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL byte_accept_timeout actual=not_accepted required=accepted byte=%0h", v);
    end
  endtask

  task automatic send_word(input bit sel, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int gap);
    drive_byte(sel, b0, gap);
    drive_byte(sel, b1, gap);
    drive_byte(sel, b2, gap);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    if (sel) b_start = 1'b0; else a_start = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while (!(sel ? b_done : a_done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(sel ? b_done : a_done)) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  task automatic check_end_a(input logic err, input int count);
    check("a_done", {31'd0, a_done}, 32'd1);
    check("a_error", {31'd0, a_error}, {31'd0, err});
    check("a_word_count", {23'd0, a_count}, count);
    check("a_cpu_hold", {31'd0, a_hold}, 32'd0);
    check("a_pending_writes", exp_a.size(), 32'd0);
  endtask

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_valid = 1'b0; a_byte = '0;
    b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_byte = '0;

    // 1. reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_byte_ready", {31'd0, a_ready}, 32'd0);
    check("rst_imem_we", {31'd0, a_we}, 32'd0);
    check("rst_imem_addr", {24'd0, a_addr}, 32'd0);
    check("rst_imem_wdata", {8'd0, a_wdata}, 32'd0);
    check("rst_cpu_hold", {31'd0, a_hold}, 32'd1);
    check("rst_done", {31'd0, a_done}, 32'd0);
    check("rst_error", {31'd0, a_error}, 32'd0);
    check("rst_word_count", {23'd0, a_count}, 32'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk); #1;

    // 2. two-word load ending in HALT
    expect_write(0, 8'd0, 24'h012345);
    expect_write(0, 8'd1, 24'hF00000);
    pulse_start(0);
    send_word(0, 8'h01, 8'h23, 8'h45, 0);
    send_word(0, 8'hF0, 8'h00, 8'h00, 0);
    wait_done(0);
    check_end_a(1'b0, 2);

    // 3. gaps between bytes; valid held through WRITE when gap is 0
    pulse_start(0);
    check("restart_clears_done", {31'd0, a_done}, 32'd0);
    check("restart_clears_count", {23'd0, a_count}, 32'd0);
    expect_write(0, 8'd0, 24'hABCDEF);
    expect_write(0, 8'd1, 24'h123456);
    expect_write(0, 8'd2, 24'hF0A5C3);
    send_word(0, 8'hAB, 8'hCD, 8'hEF, 2);
    send_word(0, 8'h12, 8'h34, 8'h56, 0);
    send_word(0, 8'hF0, 8'hA5, 8'hC3, 3);
    wait_done(0);
    check_end_a(1'b0, 3);

    // 5. reset mid-word discards the partial word
    pulse_start(0);
    drive_byte(0, 8'h55, 0);
    drive_byte(0, 8'h66, 1);
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    check("midrst_cpu_hold", {31'd0, a_hold}, 32'd1);
    check("midrst_byte_ready", {31'd0, a_ready}, 32'd0);
    check("midrst_word_count", {23'd0, a_count}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    expect_write(0, 8'd0, 24'hF12233);
    pulse_start(0);
    send_word(0, 8'hF1, 8'h22, 8'h33, 0);
    wait_done(0);
    check_end_a(1'b0, 1);

    // 6. start mid-word is ignored
    pulse_start(0);
    expect_write(0, 8'd0, 24'hA01004);
    expect_write(0, 8'd1, 24'hF00000);
    drive_byte(0, 8'hA0, 0);
    a_start = 1'b1;
    drive_byte(0, 8'h10, 0);
    a_start = 1'b0;
    drive_byte(0, 8'h04, 0);
    send_word(0, 8'hF0, 8'h00, 8'h00, 0);
    wait_done(0);
    check_end_a(1'b0, 2);

    // 4. four-word memory filled without HALT
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      expect_write(1, 8'(i), 24'h100000);
      send_word(1, 8'h10, 8'h00, 8'h00, 0);
    end
    wait_done(1);
    check("b_done", {31'd0, b_done}, 32'd1);
    check("b_error", {31'd0, b_error}, 32'd1);
    check("b_word_count", {29'd0, b_count}, 32'd4);
    check("b_cpu_hold", {31'd0, b_hold}, 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    check("b_pending_writes", exp_b.size(), 32'd0);
    check("a_idle_after_tests", exp_a.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
